// File: rtl/alu_mc.sv
// Multi-cycle handshaked 32-bit ALU: single-cycle logic/arith ops plus an optional
// 32-cycle shift-add multiplier, enabled by defining ALU_MC_MUL_EN.
module alu_mc (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] input1,
    input  logic [31:0] input2,
    input  logic [3:0]  aluCtr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] aluRes,
    output logic        zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] simple_res;

    function automatic logic [31:0] alu_op(input logic [3:0] ctr,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        r;
        sa = a;
        sb = b;
        case (ctr)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a + b;
            4'd6:    r = a - b;
            4'd7:    r = (sa < sb) ? 32'd1 : 32'd0;
            4'd12:   r = ~(a | b);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign simple_res = alu_op(aluCtr, input1, input2);
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);

`ifdef ALU_MC_MUL_EN
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [4:0]  cnt;
    logic [31:0] acc;
    logic [31:0] acc_next;

    // One partial product per BUSY cycle, selected by the current multiplier bit.
    assign acc_next = acc + (mul_b[cnt] ? (mul_a << cnt) : 32'd0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            aluRes <= 32'd0;
            zero   <= 1'b0;
`ifdef ALU_MC_MUL_EN
            mul_a  <= 32'd0;
            mul_b  <= 32'd0;
            cnt    <= 5'd0;
            acc    <= 32'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
`ifdef ALU_MC_MUL_EN
                        if (aluCtr == 4'd8) begin
                            mul_a <= input1;
                            mul_b <= input2;
                            cnt   <= 5'd0;
                            acc   <= 32'd0;
                            state <= BUSY;
                        end else begin
                            aluRes <= simple_res;
                            zero   <= (simple_res == 32'd0);
                            state  <= DONE;
                        end
`else
                        aluRes <= simple_res;
                        zero   <= (simple_res == 32'd0);
                        state  <= DONE;
`endif
                    end
                end
`ifdef ALU_MC_MUL_EN
                BUSY: begin
                    acc <= acc_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        aluRes <= acc_next;
                        zero   <= (acc_next == 32'd0);
                        state  <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
